period_detector_ro: RTL and testbench
=====================================

# period_detector_ro

Receive-side companion to the modulo-k rollover counter. It watches a single-cycle pulse train, such as a `roll_over` output, and measures the number of clock cycles between consecutive pulses. Once the same period has been seen `LOCK_COUNT` times in a row, it declares lock and reports the recovered modulus k. While locked it flags any deviation or loss of the pulse train, so it can verify or track a remote mod-k counter that shares the same clock.

## Interface
Parameters:
- `N`, default 2: width of the recovered modulus. Measurable periods are 1 to 2^N-1.
- `LOCK_COUNT`, default 2: number of consecutive equal periods required for lock. Legal range ≥ 1.

Ports:
- `i_clk` in 1: clock. All logic is on the rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_pulse` in 1: pulse train under observation, sampled every rising edge.
- `o_k` out N: recovered period. Valid while `o_locked`=1; holds its last locked value after lock is lost.
- `o_locked` out 1: high while the detector is locked.
- `o_period_valid` out 1: one-cycle strobe, raised for every pulse whose period matches `o_k`. This includes the pulse that achieves lock.
- `o_error` out 1: one-cycle strobe when a locked train deviates or times out.

## Operation
Internal registers:
- state ∈ {IDLE, MEASURE, LOCKED}
- cycle counter `cnt` (N bits)
- candidate period `cand` (N bits)
- match counter `match` (width $clog2(LOCK_COUNT+1))

Cycle counter:
- On each sampled pulse, `cnt`<=1.
- Otherwise `cnt`<=`cnt`+1.
- The measured period p of a pulse equals `cnt` at the edge that samples it.
- Timeout: no pulse at an edge where `cnt`==2^N-1. The period would exceed the range.

IDLE:
- Pulse → MEASURE. Sets `cnt`=1, `match`=0.
- No timeout is possible in IDLE.

MEASURE:
- Pulse with `match`==0 or p==`cand` → `cand`<=p, `match`<=`match`+1.
  - If the new `match`==LOCK_COUNT → LOCKED, `o_k`<=p, `o_locked`<=1, `o_period_valid`<=1.
- Pulse with p≠`cand` (and `match`>0) → `cand`<=p, `match`<=1. No error.
- Timeout → IDLE, no error.

LOCKED:
- Pulse with p==`o_k` → stay in LOCKED, `o_period_valid`<=1.
- Pulse with p≠`o_k` → `o_error`<=1, `o_locked`<=0, MEASURE with `cand`<=p, `match`<=1, `cnt`<=1.
- Timeout → `o_error`<=1, `o_locked`<=0, IDLE.

General rules:
- `i_pulse` held high continuously is a legal train with period 1.
- Reset dominates. In the reset cycle, `i_pulse` is ignored.
- After reset: state=IDLE, all counters and all outputs 0, `o_k`=0.

## Timing
- All outputs are registered. Each reflects the edge that sampled the deciding `i_pulse`.
- The strobes `o_period_valid` and `o_error` last exactly one cycle. They are never both high.
- Lock latency: LOCK_COUNT+1 pulses after IDLE. With the defaults and a period-3 train whose first pulse is at edge t0, `o_locked` rises after edge t0+6.
- Relock after a deviation needs LOCK_COUNT-1 further matching periods, because the deviating pulse counts as the first match.
- Timeout latency: 2^N-1 edges after the last pulse. That is 3 edges for N=2.
- Reset asserted mid-lock: outputs read 0 after the next rising edge. No `o_error` is generated.

## Structure
- Shared package `counter_pkg`: enum `period_state_t` {IDLE, MEASURE, LOCKED}, plus defaults for `N` and `LOCK_COUNT`.
- One sub-module: `cycle_counter_ro`, an N-bit counter with load-to-1 on pulse and a terminal-count output used as the timeout.
- The FSM, comparators and output registers live in `period_detector_ro`.
- An elaboration-time assertion enforces LOCK_COUNT ≥ 1.

## Test plan
All scenarios use N=2 and LOCK_COUNT=2.
- **Period-3 train** (pulses at edges 5, 8, 11, 14, …): after edge 11, `o_locked`=1, `o_k`=3, `o_period_valid`=1 for one cycle. After that, one `o_period_valid` strobe per pulse and `o_error`=0 throughout.
- **`i_pulse` held at 1:** after the third edge, `o_locked`=1 and `o_k`=1. `o_period_valid` stays high every cycle thereafter.
- **Locked at 3, then periods 2, 2:** at the first period-2 pulse, `o_error`=1 for one cycle, `o_locked`=0, `o_k` stays 3. At the second period-2 pulse, `o_locked`=1 and `o_k`=2.
- **Locked at 3, pulses stop:** 3 edges after the last pulse, `o_error`=1 for one cycle and `o_locked`=0. No further strobes follow.
- **Alternating periods 2, 3, 2, 3, …:** `o_locked` never rises. `o_error` and `o_period_valid` stay 0.
- **Reset asserted for one cycle while locked at 3, with `i_pulse`=1 in that cycle:** all outputs read 0 afterwards, and the pulse is ignored. The next pulse only starts MEASURE.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and default parameters for the period detector.
package counter_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} period_state_t;
  localparam int DEF_N          = 2;
  localparam int DEF_LOCK_COUNT = 2;
endpackage

// File: rtl/cycle_counter_ro.sv
// cycle_counter_ro: N-bit cycle counter, loads 1 on pulse, flags terminal count as timeout.
module cycle_counter_ro #(
  parameter int N = counter_pkg::DEF_N
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_pulse,
  output logic [N-1:0] o_cnt,
  output logic         o_tc
);
  logic [N-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_cnt <= '0;
    else         r_cnt <= i_pulse ? N'(1) : r_cnt + N'(1);
  end
  assign o_cnt = r_cnt;
  assign o_tc  = &r_cnt;
endmodule

// File: rtl/period_detector_ro.sv
// period_detector_ro: measures pulse-train period, locks after LOCK_COUNT equal periods,
// then strobes valid per matching pulse and error on deviation or timeout.
module period_detector_ro
  import counter_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_pulse,
  output logic [N-1:0] o_k,
  output logic         o_locked,
  output logic         o_period_valid,
  output logic         o_error
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  if (LOCK_COUNT < 1) begin : g_bad_lock_count
    $error("LOCK_COUNT must be >= 1");
  end
  period_state_t r_state, w_state;
  logic [N-1:0]  r_cand, w_cand, r_k, w_k, w_cnt;
  logic [MW-1:0] r_match, w_match;
  logic [MW:0]   w_match_inc;
  logic          r_locked, w_locked, r_valid, w_valid, r_error, w_error, w_tc;
  cycle_counter_ro #(.N(N)) u_cnt (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_pulse(i_pulse),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );
  assign w_match_inc = {1'b0, r_match} + (MW+1)'(1);
  always_comb begin
    w_state  = r_state;
    w_cand   = r_cand;
    w_match  = r_match;
    w_k      = r_k;
    w_locked = r_locked;
    w_valid  = 1'b0;
    w_error  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_pulse) begin
          w_state = MEASURE;
          w_match = '0;
        end
      end
      MEASURE: begin
        if (i_pulse) begin
          w_cand = w_cnt;
          if (r_match == '0 || w_cnt == r_cand) begin
            w_match = w_match_inc[MW-1:0];
            if (w_match_inc >= (MW+1)'(LOCK_COUNT)) begin
              w_state  = LOCKED;
              w_k      = w_cnt;
              w_locked = 1'b1;
              w_valid  = 1'b1;
            end
          end else begin
            w_match = MW'(1);
          end
        end else if (w_tc) begin
          w_state = IDLE;
        end
      end
      LOCKED: begin
        if (i_pulse && w_cnt == r_k) begin
          w_valid = 1'b1;
        end else if (i_pulse) begin
          // the deviating period becomes the first candidate match
          w_error  = 1'b1;
          w_locked = 1'b0;
          w_state  = MEASURE;
          w_cand   = w_cnt;
          w_match  = MW'(1);
        end else if (w_tc) begin
          w_error  = 1'b1;
          w_locked = 1'b0;
          w_state  = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cand   <= '0;
      r_match  <= '0;
      r_k      <= '0;
      r_locked <= 1'b0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cand   <= w_cand;
      r_match  <= w_match;
      r_k      <= w_k;
      r_locked <= w_locked;
      r_valid  <= w_valid;
      r_error  <= w_error;
    end
  end
  assign o_k            = r_k;
  assign o_locked       = r_locked;
  assign o_period_valid = r_valid;
  assign o_error        = r_error;
endmodule

// File: tb/tb_period_detector_ro.sv
// tb_period_detector_ro: directed scenarios for the period detector with N=2, LOCK_COUNT=2.
module tb_period_detector_ro;
  logic       i_clk = 1'b0, i_reset = 1'b0, i_pulse = 1'b0;
  logic [1:0] o_k;
  logic       o_locked, o_period_valid, o_error;
  int total = 0, bad = 0;

  period_detector_ro #(.N(2), .LOCK_COUNT(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pulse(i_pulse),
    .o_k(o_k), .o_locked(o_locked), .o_period_valid(o_period_valid), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  // drive one edge's input, then sample 1 time unit after that edge
  task automatic tick(input logic p);
    i_pulse = p;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick(1'b0);
    i_reset = 1'b0;
  endtask

  task automatic lock3();
    do_reset();
    tick(1'b1);
    repeat (2) begin tick(1'b0); tick(1'b0); tick(1'b1); end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick(1'b1);
    i_reset = 1'b0;
    total++; if (o_k !== 2'd0) begin bad++; $display("FAIL rst_k: got %0d want 0", o_k); end
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", o_locked); end
    total++; if (o_period_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", o_period_valid); end
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", o_error); end
  endtask

  task automatic test_period3();
    do_reset();
    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b1);
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL p3_early_lock: got %b want 0", o_locked); end
    tick(1'b0); tick(1'b0); tick(1'b1);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL p3_locked: got %b want 1", o_locked); end
    total++; if (o_k !== 2'd3) begin bad++; $display("FAIL p3_k: got %0d want 3", o_k); end
    total++; if (o_period_valid !== 1'b1) begin bad++; $display("FAIL p3_lock_valid: got %b want 1", o_period_valid); end
    for (int i = 0; i < 9; i++) begin
      tick(i % 3 == 2);
      total++; if (o_period_valid !== (i % 3 == 2)) begin bad++; $display("FAIL p3_valid[%0d]: got %b want %b", i, o_period_valid, i % 3 == 2); end
      total++; if (o_error !== 1'b0) begin bad++; $display("FAIL p3_error[%0d]: got %b want 0", i, o_error); end
      total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL p3_hold[%0d]: got %b want 1", i, o_locked); end
    end
  endtask

  task automatic test_hold_high();
    do_reset();
    tick(1'b1); tick(1'b1);
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL hi_early_lock: got %b want 0", o_locked); end
    tick(1'b1);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL hi_locked: got %b want 1", o_locked); end
    total++; if (o_k !== 2'd1) begin bad++; $display("FAIL hi_k: got %0d want 1", o_k); end
    for (int i = 0; i < 5; i++) begin
      total++; if (o_period_valid !== 1'b1) begin bad++; $display("FAIL hi_valid[%0d]: got %b want 1", i, o_period_valid); end
      tick(1'b1);
    end
  endtask

  task automatic test_deviation();
    lock3();
    tick(1'b0); tick(1'b1);
    total++; if (o_error !== 1'b1) begin bad++; $display("FAIL dev_error: got %b want 1", o_error); end
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL dev_unlock: got %b want 0", o_locked); end
    total++; if (o_k !== 2'd3) begin bad++; $display("FAIL dev_k_hold: got %0d want 3", o_k); end
    total++; if (o_period_valid !== 1'b0) begin bad++; $display("FAIL dev_valid: got %b want 0", o_period_valid); end
    tick(1'b0);
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL dev_error_len: got %b want 0", o_error); end
    tick(1'b1);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL dev_relock: got %b want 1", o_locked); end
    total++; if (o_k !== 2'd2) begin bad++; $display("FAIL dev_k_new: got %0d want 2", o_k); end
    total++; if (o_period_valid !== 1'b1) begin bad++; $display("FAIL dev_relock_valid: got %b want 1", o_period_valid); end
  endtask

  task automatic test_timeout();
    lock3();
    tick(1'b0); tick(1'b0);
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", o_error); end
    tick(1'b0);
    total++; if (o_error !== 1'b1) begin bad++; $display("FAIL to_error: got %b want 1", o_error); end
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL to_unlock: got %b want 0", o_locked); end
    total++; if (o_k !== 2'd3) begin bad++; $display("FAIL to_k_hold: got %0d want 3", o_k); end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0);
      total++; if ({o_error, o_period_valid, o_locked} !== 3'b000) begin bad++; $display("FAIL to_quiet[%0d]: got %b want 000", i, {o_error, o_period_valid, o_locked}); end
    end
  endtask

  task automatic test_alternate();
    do_reset();
    tick(1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(i % 5 == 1 || i % 5 == 4);
      total++; if ({o_error, o_period_valid, o_locked} !== 3'b000) begin bad++; $display("FAIL alt[%0d]: got %b want 000", i, {o_error, o_period_valid, o_locked}); end
    end
  endtask

  task automatic test_reset_lock();
    lock3();
    tick(1'b0); tick(1'b0);
    i_reset = 1'b1;
    tick(1'b1);
    i_reset = 1'b0;
    total++; if ({o_error, o_period_valid, o_locked, o_k} !== 5'b0) begin bad++; $display("FAIL rl_clear: got %b want 00000", {o_error, o_period_valid, o_locked, o_k}); end
    tick(1'b0); tick(1'b1);
    tick(1'b0); tick(1'b1);
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL rl_ignored_pulse: got %b want 0", o_locked); end
    tick(1'b0); tick(1'b1);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL rl_relock: got %b want 1", o_locked); end
    total++; if (o_k !== 2'd2) begin bad++; $display("FAIL rl_k: got %0d want 2", o_k); end
  endtask

  task automatic test_measure_timeout();
    do_reset();
    tick(1'b1); tick(1'b0); tick(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      total++; if (o_error !== 1'b0) begin bad++; $display("FAIL mto_error[%0d]: got %b want 0", i, o_error); end
    end
    tick(1'b1); tick(1'b0); tick(1'b1);
    total++; if (o_locked !== 1'b0) begin bad++; $display("FAIL mto_early_lock: got %b want 0", o_locked); end
    tick(1'b0); tick(1'b1);
    total++; if (o_locked !== 1'b1) begin bad++; $display("FAIL mto_lock: got %b want 1", o_locked); end
  endtask

  initial begin
    #1;
    test_reset();
    test_period3();
    test_hold_high();
    test_deviation();
    test_timeout();
    test_alternate();
    test_reset_lock();
    test_measure_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
